// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the multiplier pipeline: field widths, constants,
// rounding-mode encodings and the multiply-stage FSM states.
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int PROD_W = 48;

  localparam logic [9:0]  BIAS      = 10'd127;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [22:0] QNAN_FRAC = 23'h400000;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTN = 2'b01,
    RM_RTP = 2'b10,
    RM_RTZ = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;
endpackage

// File: rtl/fp32_unpack.sv
// Combinational FP32 operand unpacker: sign, hidden-bit mantissa, effective
// exponent (denormals read as exponent 1) and NaN/Inf/zero classification.
module fp32_unpack
  import fpu_pkg::*;
(
  input  logic [31:0]       i_op,
  output logic              o_sign,
  output logic [MANT_W-1:0] o_mant,
  output logic [EXP_W-1:0]  o_exp,
  output logic              o_nan,
  output logic              o_inf,
  output logic              o_zero
);
  logic [EXP_W-1:0]  w_ex;
  logic [FRAC_W-1:0] w_frac;
  logic              w_ex_zero;
  logic              w_ex_max;
  logic              w_frac_zero;

  assign w_ex        = i_op[30:23];
  assign w_frac      = i_op[22:0];
  assign w_ex_zero   = (w_ex == 8'h00);
  assign w_ex_max    = (w_ex == EXP_MAX);
  assign w_frac_zero = (w_frac == 23'h000000);

  assign o_sign = i_op[31];
  assign o_mant = {~w_ex_zero, w_frac};
  assign o_exp  = w_ex_zero ? 8'd1 : w_ex;
  assign o_nan  = w_ex_max & ~w_frac_zero;
  assign o_inf  = w_ex_max & w_frac_zero;
  assign o_zero = w_ex_zero & w_frac_zero;
endmodule

// File: rtl/fmul_mant_mul.sv
// FP32 multiply stage: unpack/classify, iterative shift-add 24x24 mantissa product.
// Optional macro FMUL_EARLY_OUT_EN: zero/inf/NaN operands skip the iterations.
module fmul_mant_mul
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  rm_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] z,
  output logic [9:0]  exp10,
  output logic        sign,
  output logic        is_nan,
  output logic        is_inf,
  output logic [22:0] inf_nan_frac,
  output logic [1:0]  rm
);
  localparam int ITER = 24 / BITS_PER_CYCLE;

  state_e              r_state;
  state_e              w_next;
  state_e              w_issue_dst;
  logic                w_accept;
  logic                w_load_out;

  logic                w_sa, w_sb;
  logic [MANT_W-1:0]   w_ma, w_mb;
  logic [EXP_W-1:0]    w_ea, w_eb;
  logic                w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic                w_nan, w_inf;
  logic [9:0]          w_exp10;

  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_mcand;
  logic [MANT_W-1:0]   r_mplier;
  logic [4:0]          r_cnt;
  logic [9:0]          r_exp;
  logic                r_sign, r_nan, r_inf;
  logic [1:0]          r_rm;
  logic [PROD_W-1:0]   w_pp;
  logic [PROD_W-1:0]   w_acc_next;

  logic [47:0]         r_z;
  logic [9:0]          r_exp10;
  logic                r_sign_o, r_nan_o, r_inf_o, r_out_valid;
  logic [22:0]         r_frac_o;
  logic [1:0]          r_rm_o;

  fp32_unpack u_unpack_a (
    .i_op(a), .o_sign(w_sa), .o_mant(w_ma), .o_exp(w_ea),
    .o_nan(w_nan_a), .o_inf(w_inf_a), .o_zero(w_zero_a)
  );

  fp32_unpack u_unpack_b (
    .i_op(b), .o_sign(w_sb), .o_mant(w_mb), .o_exp(w_eb),
    .o_nan(w_nan_b), .o_inf(w_inf_b), .o_zero(w_zero_b)
  );

  assign w_nan   = w_nan_a | w_nan_b | (w_inf_a & w_zero_b) | (w_zero_a & w_inf_b);
  assign w_inf   = (w_inf_a | w_inf_b) & ~w_nan;
  assign w_exp10 = {2'b00, w_ea} + {2'b00, w_eb} - BIAS;

  // Multiplicand is pre-shifted to the weight of the multiplier bits being retired.
  assign w_pp       = r_mcand * PROD_W'(r_mplier[BITS_PER_CYCLE-1:0]);
  assign w_acc_next = r_acc + w_pp;

`ifdef FMUL_EARLY_OUT_EN
  logic w_special;
  assign w_special   = w_nan_a | w_nan_b | w_inf_a | w_inf_b | w_zero_a | w_zero_b;
  assign w_issue_dst = w_special ? S_DONE : S_BUSY;
`else
  assign w_issue_dst = S_BUSY;
`endif

  assign in_ready = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);

  // Next-state and accept decode; flush overrides every handshake.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            w_accept = 1'b1;
            w_next   = w_issue_dst;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_BUSY: begin
          if (r_cnt == 5'd0) w_next = S_DONE;
          else               w_next = S_BUSY;
        end
        S_DONE: begin
          if (out_ready && in_valid) begin
            w_accept = 1'b1;
            w_next   = w_issue_dst;
          end else if (out_ready) begin
            w_next = S_IDLE;
          end else begin
            w_next = S_DONE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_load_out = (r_state == S_BUSY) && (w_next == S_DONE);

  // State register; out_valid tracks entry into / stay in DONE.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == S_DONE);
    end
  end

  // Operand capture and shift-add iteration.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_acc    <= 48'h0;
      r_mcand  <= 48'h0;
      r_mplier <= 24'h0;
      r_cnt    <= 5'd0;
      r_exp    <= 10'h0;
      r_sign   <= 1'b0;
      r_nan    <= 1'b0;
      r_inf    <= 1'b0;
      r_rm     <= 2'b00;
    end else if (w_accept) begin
      r_acc    <= 48'h0;
      r_mcand  <= {24'h0, w_ma};
      r_mplier <= w_mb;
      r_cnt    <= 5'(ITER - 1);
      r_exp    <= w_exp10;
      r_sign   <= w_sa ^ w_sb;
      r_nan    <= w_nan;
      r_inf    <= w_inf;
      r_rm     <= rm_in;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt - 5'd1;
    end
  end

  // Result registers, held stable for the whole DONE residency.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_z      <= 48'h0;
      r_exp10  <= 10'h0;
      r_sign_o <= 1'b0;
      r_nan_o  <= 1'b0;
      r_inf_o  <= 1'b0;
      r_frac_o <= 23'h0;
      r_rm_o   <= 2'b00;
    end else if (w_load_out) begin
      r_z      <= w_acc_next;
      r_exp10  <= r_exp;
      r_sign_o <= r_sign;
      r_nan_o  <= r_nan;
      r_inf_o  <= r_inf;
      r_frac_o <= r_nan ? QNAN_FRAC : 23'h0;
      r_rm_o   <= r_rm;
    end else if (w_accept && (w_issue_dst == S_DONE)) begin
      r_z      <= 48'h0;
      r_exp10  <= w_exp10;
      r_sign_o <= w_sa ^ w_sb;
      r_nan_o  <= w_nan;
      r_inf_o  <= w_inf;
      r_frac_o <= w_nan ? QNAN_FRAC : 23'h0;
      r_rm_o   <= rm_in;
    end
  end

  assign out_valid    = r_out_valid;
  assign z            = r_z;
  assign exp10        = r_exp10;
  assign sign         = r_sign_o;
  assign is_nan       = r_nan_o;
  assign is_inf       = r_inf_o;
  assign inf_nan_frac = r_frac_o;
  assign rm           = r_rm_o;
endmodule

// File: tb/tb_fmul_mant_mul.sv
// Self-checking bench for fmul_mant_mul: directed spec vectors, randomized
// operands against an arithmetic reference model, backpressure, flush and reset.
module tb_fmul_mant_mul;
`ifdef FMUL_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  localparam int LAT = 13;

  typedef struct packed {
    logic [47:0] z;
    logic [9:0]  e;
    logic        s;
    logic        n;
    logic        i;
    logic [22:0] f;
    logic [1:0]  r;
  } res_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic [1:0]  rm_in = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [47:0] z;
  logic [9:0]  exp10;
  logic        sign, is_nan, is_inf;
  logic [22:0] inf_nan_frac;
  logic [1:0]  rm;

  int n_vec = 0;
  int n_err = 0;

  fmul_mant_mul dut (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .rm_in(rm_in), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .exp10(exp10), .sign(sign), .is_nan(is_nan), .is_inf(is_inf),
    .inf_nan_frac(inf_nan_frac), .rm(rm)
  );

  always #5 clk = ~clk;

  function automatic bit is_special(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:0] == 31'h0);
  endfunction

  // Reference straight from IEEE field arithmetic.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [1:0] r);
    res_t o;
    int   ex, ey;
    longint mx, my;
    bit nx, ny, ix, iy, zx, zy;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = longint'(x[22:0]) + ((ex != 0) ? 64'd8388608 : 64'd0);
    my = longint'(y[22:0]) + ((ey != 0) ? 64'd8388608 : 64'd0);
    nx = (ex == 255) && (x[22:0] != 0);
    ny = (ey == 255) && (y[22:0] != 0);
    ix = (ex == 255) && (x[22:0] == 0);
    iy = (ey == 255) && (y[22:0] == 0);
    zx = (ex == 0) && (x[22:0] == 0);
    zy = (ey == 0) && (y[22:0] == 0);
    if (ex == 0) ex = 1;
    if (ey == 0) ey = 1;
    o.z = 48'(mx * my);
    if (EARLY && is_special(x) || EARLY && is_special(y)) o.z = 48'h0;
    o.e = 10'(ex + ey - 127);
    o.s = x[31] ^ y[31];
    o.n = nx | ny | (ix & zy) | (zx & iy);
    o.i = (ix | iy) & ~o.n;
    o.f = o.n ? 23'h400000 : 23'h0;
    o.r = r;
    return o;
  endfunction

  // Drive one operand, wait for its acceptance and then for out_valid (bounded).
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] trm,
                       output int lat);
    int guard;
    guard = 0;
    in_valid = 1'b1; a = ta; b = tb; rm_in = trm;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  function automatic res_t observed();
    return {z, exp10, sign, is_nan, is_inf, inf_nan_frac, rm};
  endfunction

  task automatic test_reset();
    res_t zero_r;
    zero_r = '0;
    clrn = 1'b0;
    #12;
    n_vec++;
    if ({out_valid, observed()} !== {1'b0, zero_r}) begin
      n_err++; $display("FAIL reset_outputs got v=%b %h want v=0 all zero", out_valid, observed());
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [6] = '{32'h3FC00000, 32'h00000001, 32'h80000001, 32'h7F800000, 32'h7F800000, 32'h00000000};
    logic [31:0] tb [6] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h00000000, 32'hC0000000, 32'h3F800000};
    logic [47:0] tz [6] = '{48'h600000000000, 48'h000000800000, 48'h000000800000, 48'h0, 48'h400000000000, 48'h0};
    logic [9:0]  te [6] = '{10'h080, 10'h001, 10'h001, 10'h081, 10'h100, 10'h001};
    logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        tn [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ti [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [22:0] tf [6] = '{23'h0, 23'h0, 23'h0, 23'h400000, 23'h0, 23'h0};
    res_t exp_r;
    int   lat, lat_exp;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      issue(ta[k], tb[k], 2'(k), lat);
      lat_exp = (EARLY && (is_special(ta[k]) || is_special(tb[k]))) ? 1 : LAT;
      exp_r = {tz[k], te[k], ts[k], tn[k], ti[k], tf[k], 2'(k)};
      if (EARLY && (is_special(ta[k]) || is_special(tb[k]))) exp_r.z = 48'h0;
      n_vec++;
      if (lat != lat_exp) begin
        n_err++; $display("FAIL directed%0d_latency got %0d want %0d", k, lat, lat_exp);
      end
      n_vec++;
      if (observed() !== exp_r) begin
        n_err++; $display("FAIL directed%0d_fields got %h want %h", k, observed(), exp_r);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] op [2];
    logic [1:0]  r;
    res_t exp_r;
    int   lat, lat_exp;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      for (int j = 0; j < 2; j++) begin
        op[j] = $urandom;
        case ($urandom_range(0, 5))
          3: op[j][30:23] = 8'hFF;
          4: op[j][30:0]  = 31'h0;
          5: op[j][30:23] = 8'h00;
          default: op[j] = op[j];
        endcase
        if ($urandom_range(0, 3) == 0) op[j][22:0] = 23'h0;
      end
      r = 2'($urandom);
      issue(op[0], op[1], r, lat);
      exp_r = model(op[0], op[1], r);
      lat_exp = (EARLY && (is_special(op[0]) || is_special(op[1]))) ? 1 : LAT;
      n_vec++;
      if (lat != lat_exp) begin
        n_err++; $display("FAIL random%0d_latency a=%h b=%h got %0d want %0d", k, op[0], op[1], lat, lat_exp);
      end
      n_vec++;
      if (observed() !== exp_r) begin
        n_err++; $display("FAIL random%0d a=%h b=%h got %h want %h", k, op[0], op[1], observed(), exp_r);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    res_t held, exp_r;
    int   lat;
    bit   stable;
    out_ready = 1'b0;
    issue(32'h40400000, 32'h40A00000, 2'b10, lat);
    held = observed();
    n_vec++;
    if (held !== model(32'h40400000, 32'h40A00000, 2'b10)) begin
      n_err++; $display("FAIL bp_first got %h want %h", held, model(32'h40400000, 32'h40A00000, 2'b10));
    end
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || observed() !== held) stable = 1'b0;
    end
    n_vec++;
    if (!stable) begin
      n_err++; $display("FAIL bp_hold got v=%b rdy=%b %h want v=1 rdy=0 %h", out_valid, in_ready, observed(), held);
    end
    out_ready = 1'b1; in_valid = 1'b1; a = 32'hBFC00000; b = 32'h3FC00000; rm_in = 2'b01;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_in_ready got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_valid_drop got %b want 0", out_valid);
    end
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    exp_r = model(32'hBFC00000, 32'h3FC00000, 2'b01);
    n_vec++;
    if (lat != LAT || observed() !== exp_r) begin
      n_err++; $display("FAIL b2b_second got lat=%0d %h want lat=%0d %h", lat, observed(), LAT, exp_r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bit seen;
    out_ready = 1'b1;
    in_valid = 1'b1; a = 32'h3F800000; b = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_in_ready got %b want 1", in_ready);
    end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++;
    if (seen) begin
      n_err++; $display("FAIL flush_no_valid got 1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    res_t zero_r, exp_r;
    int   lat;
    zero_r = '0;
    in_valid = 1'b1; a = 32'h3FC00000; b = 32'h40000000; rm_in = 2'b11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 clrn = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, observed()} !== {1'b0, zero_r}) begin
      n_err++; $display("FAIL midreset_outputs got v=%b %h want all zero", out_valid, observed());
    end
    @(posedge clk); #1;
    clrn = 1'b1;
    @(posedge clk); #1;
    issue(32'h40490FDB, 32'hC02DF854, 2'b10, lat);
    exp_r = model(32'h40490FDB, 32'hC02DF854, 2'b10);
    n_vec++;
    if (lat != LAT || observed() !== exp_r) begin
      n_err++; $display("FAIL midreset_after got lat=%0d %h want lat=%0d %h", lat, observed(), LAT, exp_r);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fmul_mant_mul.md
Name: fmul_mant_mul

Overview:
- Multi-cycle multiply stage of the FP32 multiplier, directly upstream of the normaliser/rounder.
- Unpacks two IEEE-754 single operands, classifies special values and computes sign, biased pre-normalisation exponent and 24x24 mantissa product with an iterative shift-add datapath.
- Hands {z, exp10, sign, is_nan, is_inf, inf_nan_frac, rm} to the normaliser over a valid/ready handshake.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; legal values 1, 2, 4, 8 (must divide 24); ITER = 24/BITS_PER_CYCLE.

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  asynchronous active-low reset
- flush  in  1  synchronous cancel; abandons any in-flight or held operation
- in_valid  in  1  operands valid
- in_ready  out  1  stage can accept operands
- a  in  32  operand A, FP32
- b  in  32  operand B, FP32
- rm_in  in  2  rounding mode, captured with operands
- out_valid  out  1  result fields valid
- out_ready  in  1  normaliser accepts result
- z  out  48  unsigned mantissa product, binary point between bits 46 and 45
- exp10  out  10  two's-complement exponent ea'+eb'-127
- sign  out  1  sign_a XOR sign_b
- is_nan  out  1  result is NaN
- is_inf  out  1  result is infinity (non-NaN)
- inf_nan_frac  out  23  fraction for special results
- rm  out  2  captured rounding mode

Behaviour:
- Reset (clrn=0, asynchronous): state IDLE; out_valid=0; z, exp10, sign, is_nan, is_inf, inf_nan_frac, rm all 0; accumulator and counter 0.
- Unpack: ex=0 means denormal/zero; mantissa = {ex!=0, frac}; effective exponent ex' = ex + (ex==0). exp10 = {2'b0,ea'} + {2'b0,eb'} - 10'd127, 10-bit wrap.
- Class: nan_x = (ex==FF)&(frac!=0); inf_x = (ex==FF)&(frac==0); zero_x = (ex==0)&(frac==0).
- is_nan = nan_a | nan_b | (inf_a&zero_b) | (zero_a&inf_b); is_inf = (inf_a|inf_b) & ~is_nan.
- inf_nan_frac = 23'h400000 if is_nan, else 23'h000000.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, capture operands, rm and class; clear accumulator; counter=ITER-1; go to BUSY.
  - BUSY: each cycle add (mant_a x next BITS_PER_CYCLE LSBs of mant_b), shifted to the correct weight, into the 48-bit accumulator. When counter==0, register outputs, set out_valid, go to DONE.
  - DONE: outputs held stable while out_ready=0. On out_ready: out_valid drops unless a new operand is accepted the same cycle.
- in_ready = IDLE | (DONE & out_ready). Accepting in DONE gives back-to-back issue with no bubble: DONE->BUSY.
- Latency: ITER+1 cycles from the accept edge to out_valid (13 at default). Throughput is one result per ITER+1 cycles.
- flush (priority over all handshakes except reset): next state IDLE, out_valid=0, input not accepted that cycle; data registers may keep stale values.
- Special operands run the full latency. z is the true product, and the downstream stage selects by is_nan/is_inf.
- Asserting clrn mid-operation discards the operation; no partial output is ever flagged valid.

Optional Feature:
- Macro: FMUL_EARLY_OUT_EN.
- Defined: if any operand is zero, inf or NaN, IDLE moves directly to DONE on the accept edge. out_valid is 1 cycle after accept, with z=48'h0 and exp10/sign/flags/rm as normal.
- Not defined: every operation takes ITER+1 cycles.

Decomposition:
- Shared package fpu_pkg holds:
  - FP32 field widths (EXP_W=8, FRAC_W=23, MANT_W=24, PROD_W=48);
  - BIAS=127, EXP_MAX=8'hFF, QNAN_FRAC=23'h400000;
  - rounding-mode encodings (RNE=00, RTN=01, RTP=10, RTZ=11);
  - FSM state enum.
- One sub-module is natural: fp32_unpack, purely combinational. It outputs mantissa, effective exponent and the nan/inf/zero flags for one operand, instantiated twice.

Test Plan:
- 1.5x2.0: a=3FC00000, b=40000000, out_ready=1 -> out_valid exactly 13 cycles after accept; z=48'h600000000000, exp10=10'h080, sign=0, is_nan=0, is_inf=0.
- Denormal: a=00000001, b=3F800000 -> z=48'h000000800000, exp10=10'h001. Also a=80000001 (sign bit set), same b -> sign=1.
- Specials: a=7F800000, b=00000000 -> is_nan=1, is_inf=0, inf_nan_frac=400000. a=7F800000, b=C0000000 -> is_inf=1, sign=1, inf_nan_frac=0.
- Backpressure/back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs and out_valid stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 -> new operand accepted that edge; next result valid 13 cycles later.
- Flush/reset: flush at BUSY cycle 6 -> out_valid never rises, in_ready=1 next cycle. clrn pulse mid-BUSY -> all outputs 0 immediately, the following operation is correct.
- FMUL_EARLY_OUT_EN: a=00000000, b=3F800000 -> out_valid 1 cycle after accept, z=0, exp10=10'h001. Without the macro, 13 cycles.
